task_generator: RTL and testbench
=================================

Name: task_generator

Overview:
- Buffers incoming push tasks (tree ID, priority, payload) in PRIORITY_NUM strict-priority FIFO queues sharing one storage array of FIFO_SIZE entries.
- On each pop it returns the oldest task of the highest-priority non-empty queue.
- Sits in front of the BMW PIFO tree array and feeds tasks tagged with their target tree ID.

Parameters:
PTW, 16, payload priority-field width; payload width is MTW+PTW
MTW, 2, metadata-field width (equals TREE_NUM_BITS in system use)
CTW, 16, width of per-queue occupancy counters; must be >= log2(QDEPTH)+1
LEVEL, 4, tree depth of downstream PIFO; informational only, no effect on logic
TREE_NUM, 4, number of trees; TREE_NUM_BITS = clog2(TREE_NUM)
PRIORITY_NUM, 16, number of priority queues; PRIORITY_BITS = clog2(PRIORITY_NUM)
FIFO_SIZE, 2048, total entries; QDEPTH = FIFO_SIZE/PRIORITY_NUM (power of two required)

Ports:
i_clk  in  1  clock, all state on rising edge
i_arst_n  in  1  asynchronous active-low reset
i_push  in  1  push strobe, one task per cycle
i_push_tree_id  in  TREE_NUM_BITS  target tree of pushed task
i_push_priority  in  PRIORITY_BITS  queue select; 0 = highest priority
i_push_data  in  MTW+PTW  task payload
i_pop  in  1  pop strobe
o_pop_tree_id  out  TREE_NUM_BITS  tree ID of popped task (registered)
o_pop_data  out  MTW+PTW  payload of popped task (registered)
o_task_fifo_full  out  1  high when any priority queue holds QDEPTH entries (registered)

Behaviour:
- Reset (async assert, sync release): all queue read/write pointers and counts = 0; o_pop_tree_id = 0, o_pop_data = 0, o_task_fifo_full = 0. Storage contents need no reset.
- Storage:
  - FIFO_SIZE x (TREE_NUM_BITS+MTW+PTW) array, queue p owns addresses p*QDEPTH .. p*QDEPTH+QDEPTH-1.
  - Per-queue write pointer, read pointer (log2(QDEPTH) bits, wrap modulo QDEPTH) and CTW-bit count.
- Push:
  - On a rising edge with i_push=1, if count[i_push_priority] < QDEPTH, write {tree_id, data} at that queue's wptr; wptr+1, count+1.
  - If that queue is full, the push is silently dropped with no state change.
- Pop:
  - On a rising edge with i_pop=1, select the lowest-index queue with count>0, evaluated on pre-edge state.
  - If one exists: o_pop_tree_id/o_pop_data <= head entry; rptr+1, count-1. Latency: data visible the cycle after the pop edge.
  - If all queues are empty: outputs <= 0, no state change.
  - When i_pop=0, outputs hold their last value.
- Ordering: FIFO within a priority, strict priority across queues; tree ID does not affect ordering.
- Simultaneous push and pop in the same cycle are both performed:
  - A push to an empty queue is not poppable in that same cycle.
  - Same-queue push+pop when full: push is dropped (pre-edge full), pop proceeds.
  - Same-queue push+pop when non-full: count unchanged.
- o_task_fifo_full: registered OR over queues of (next count == QDEPTH); reflects the post-edge state.
- Reset mid-operation: all queued tasks discarded immediately; outputs to reset values.

Test Plan:
- Reset: hold i_arst_n=0 for 400 ns -> o_pop_data=0, o_pop_tree_id=0, o_task_fifo_full=0; pop right after release -> outputs stay 0.
- Strict priority:
  - Stimulus: for j=1..4, for i=1..3 push tree i, priority i, data 4096*i+j (12 pushes), then 12 consecutive pops.
  - Required pop order: 4097,4098,4099,4100 (tree 1), then 8193..8196 (tree 2), then 12289..12292 (tree 3), each one cycle after its pop.
  - A 13th pop returns data 0, tree 0.
- FIFO within priority: push 5 tasks at priority 7 with data 1..5 and tree IDs cycling 0..3 -> pops return 1..5 with matching tree IDs.
- Full/drop:
  - Push QDEPTH=128 tasks to priority 0 -> o_task_fifo_full=1 after the 128th edge.
  - 129th push is dropped; 128 pops return the original sequence.
  - Full deasserts after the first pop.
- Simultaneous push+pop: with priority 2 empty, push to priority 2 while popping -> pop returns 0; next pop returns the pushed task.
- Mid-operation reset: push 3 tasks, assert reset, release, pop -> data 0; o_task_fifo_full=0.

Source files
------------

// File: rtl/task_generator.sv
// ---------------------------------------------------------------------------
// task_generator
//
// Buffers pushed tasks (tree ID + payload) in PRIORITY_NUM strict-priority
// FIFO queues that share one storage array of FIFO_SIZE entries. Queue p owns
// the contiguous address block p*QDEPTH .. p*QDEPTH+QDEPTH-1. A pop returns
// the oldest entry of the lowest-index (highest-priority) non-empty queue.
//
// Ports:
//   i_clk            clock, all state updates on the rising edge
//   i_arst_n         asynchronous active-low reset
//   i_push           push strobe (one task per cycle)
//   i_push_tree_id   target tree of the pushed task
//   i_push_priority  queue select, 0 = highest priority
//   i_push_data      task payload (MTW+PTW bits)
//   i_pop            pop strobe
//   o_pop_tree_id    tree ID of the popped task (registered)
//   o_pop_data       payload of the popped task (registered)
//   o_task_fifo_full high when any queue holds QDEPTH entries (registered)
// ---------------------------------------------------------------------------
module task_generator #(
  parameter int PTW          = 16,
  parameter int MTW          = 2,
  parameter int CTW          = 16,
  parameter int LEVEL        = 4,
  parameter int TREE_NUM     = 4,
  parameter int PRIORITY_NUM = 16,
  parameter int FIFO_SIZE    = 2048
) (
  input  logic                                i_clk,
  input  logic                                i_arst_n,
  input  logic                                i_push,
  input  logic [$clog2(TREE_NUM)-1:0]         i_push_tree_id,
  input  logic [$clog2(PRIORITY_NUM)-1:0]     i_push_priority,
  input  logic [MTW+PTW-1:0]                  i_push_data,
  input  logic                                i_pop,
  output logic [$clog2(TREE_NUM)-1:0]         o_pop_tree_id,
  output logic [MTW+PTW-1:0]                  o_pop_data,
  output logic                                o_task_fifo_full
);

  localparam int TREE_NUM_BITS = $clog2(TREE_NUM);
  localparam int PRIORITY_BITS = $clog2(PRIORITY_NUM);
  localparam int QDEPTH        = FIFO_SIZE / PRIORITY_NUM;
  localparam int QAW           = $clog2(QDEPTH);
  localparam int DW            = MTW + PTW;
  localparam int EW            = TREE_NUM_BITS + DW;

  logic [EW-1:0]            mem [FIFO_SIZE];
  logic [QAW-1:0]           wptr [PRIORITY_NUM];
  logic [QAW-1:0]           rptr [PRIORITY_NUM];
  logic [CTW-1:0]           count [PRIORITY_NUM];
  logic [CTW-1:0]           cnt_next [PRIORITY_NUM];

  logic                     push_ok;
  logic                     pop_valid;
  logic                     pop_do;
  logic [PRIORITY_BITS-1:0] pop_sel;
  logic [EW-1:0]            head;
  logic                     full_next;

  // A push is accepted only if its queue was below QDEPTH before the edge,
  // so a simultaneous pop from a full queue cannot make room for it.
  assign push_ok = i_push && (count[i_push_priority] < CTW'(QDEPTH));
  assign pop_do  = i_pop && pop_valid;

  // Because QDEPTH is a power of two, the queue index concatenated with the
  // in-queue pointer is exactly the flat storage address.
  assign head = mem[{pop_sel, rptr[pop_sel]}];

  // Scan from the lowest priority upward so the last hit, the lowest index,
  // wins. Based on pre-edge counts, so a push this cycle is not yet visible.
  always_comb begin
    pop_valid = 1'b0;
    pop_sel   = '0;
    for (int q = PRIORITY_NUM - 1; q >= 0; q--) begin
      if (count[q] != '0) begin
        pop_valid = 1'b1;
        pop_sel   = PRIORITY_BITS'(q);
      end
    end
  end

  // Post-edge occupancy per queue; a same-queue push and pop cancel out.
  always_comb begin
    full_next = 1'b0;
    for (int q = 0; q < PRIORITY_NUM; q++) begin
      cnt_next[q] = count[q];
      if (push_ok && (i_push_priority == PRIORITY_BITS'(q)))
        cnt_next[q] = cnt_next[q] + CTW'(1);
      if (pop_do && (pop_sel == PRIORITY_BITS'(q)))
        cnt_next[q] = cnt_next[q] - CTW'(1);
      if (cnt_next[q] == CTW'(QDEPTH))
        full_next = 1'b1;
    end
  end

  // Storage write port; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (push_ok)
      mem[{i_push_priority, wptr[i_push_priority]}] <= {i_push_tree_id, i_push_data};
  end

  // Queue bookkeeping and registered outputs.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int q = 0; q < PRIORITY_NUM; q++) begin
        wptr[q]  <= '0;
        rptr[q]  <= '0;
        count[q] <= '0;
      end
      o_pop_tree_id    <= '0;
      o_pop_data       <= '0;
      o_task_fifo_full <= 1'b0;
    end else begin
      for (int q = 0; q < PRIORITY_NUM; q++) begin
        count[q] <= cnt_next[q];
        if (push_ok && (i_push_priority == PRIORITY_BITS'(q)))
          wptr[q] <= wptr[q] + QAW'(1);
        if (pop_do && (pop_sel == PRIORITY_BITS'(q)))
          rptr[q] <= rptr[q] + QAW'(1);
      end
      // Popping with every queue empty clears the outputs; no pop holds them.
      if (i_pop) begin
        if (pop_valid) begin
          o_pop_tree_id <= head[EW-1:DW];
          o_pop_data    <= head[DW-1:0];
        end else begin
          o_pop_tree_id <= '0;
          o_pop_data    <= '0;
        end
      end
      o_task_fifo_full <= full_next;
    end
  end

endmodule

// File: tb/tb_task_generator.sv
module tb_task_generator;

  localparam int QD = 128;
  localparam int NQ = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0;
  logic [1:0]  push_tree = '0;
  logic [3:0]  push_prio = '0;
  logic [17:0] push_data = '0;
  logic        pop = 1'b0;
  logic [1:0]  pop_tree;
  logic [17:0] pop_data;
  logic        fifo_full;

  // Reference model: one queue of {tree, data} per priority.
  logic [19:0] mq [NQ][$];
  logic [1:0]  exp_tree = '0;
  logic [17:0] exp_data = '0;
  logic        exp_full = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  task_generator dut (
    .i_clk            (clk),
    .i_arst_n         (rst_n),
    .i_push           (push),
    .i_push_tree_id   (push_tree),
    .i_push_priority  (push_prio),
    .i_push_data      (push_data),
    .i_pop            (pop),
    .o_pop_tree_id    (pop_tree),
    .o_pop_data       (pop_data),
    .o_task_fifo_full (fifo_full)
  );

  // One clock cycle of stimulus; the model advances at the edge and the
  // bench samples 1 ns later.
  task automatic cycle(input logic p, input logic [1:0] t, input logic [3:0] pr,
                       input logic [17:0] d, input logic po);
    bit found;
    int sel;
    bit push_ok;
    logic [19:0] e;
    @(negedge clk);
    push = p; push_tree = t; push_prio = pr; push_data = d; pop = po;
    @(posedge clk);
    found = 0; sel = 0;
    for (int q = 0; q < NQ; q++)
      if (!found && mq[q].size() > 0) begin found = 1; sel = q; end
    push_ok = p && (mq[pr].size() < QD);
    if (po) begin
      if (found) begin
        e = mq[sel].pop_front();
        exp_tree = e[19:18];
        exp_data = e[17:0];
      end else begin
        exp_tree = '0;
        exp_data = '0;
      end
    end
    if (push_ok) mq[pr].push_back({t, d});
    exp_full = 1'b0;
    for (int q = 0; q < NQ; q++)
      if (mq[q].size() == QD) exp_full = 1'b1;
    #1;
  endtask

  task automatic do_reset(input int hold_ns);
    @(negedge clk);
    push = 0; pop = 0;
    rst_n = 1'b0;
    for (int q = 0; q < NQ; q++) mq[q].delete();
    exp_tree = '0; exp_data = '0; exp_full = 1'b0;
    #(hold_ns);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(400);
    tests_run++;
    if (pop_data !== 18'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got %0d want 0", pop_data);
    end
    tests_run++;
    if (pop_tree !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_tree: got %0d want 0", pop_tree);
    end
    tests_run++;
    if (fifo_full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_full: got %0b want 0", fifo_full);
    end
    cycle(0, 0, 0, 0, 1);
    tests_run++;
    if (pop_data !== 18'd0 || pop_tree !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pop_empty: got tree %0d data %0d want 0/0", pop_tree, pop_data);
    end
  endtask

  task automatic test_strict_priority();
    logic [17:0] want;
    for (int j = 1; j <= 4; j++)
      for (int i = 1; i <= 3; i++)
        cycle(1, 2'(i), 4'(i), 18'(4096 * i + j), 0);
    for (int i = 1; i <= 3; i++)
      for (int j = 1; j <= 4; j++) begin
        cycle(0, 0, 0, 0, 1);
        want = 18'(4096 * i + j);
        tests_run++;
        if (pop_data !== want || pop_tree !== 2'(i) || pop_data !== exp_data) begin
          tests_failed++;
          $display("[TB] FAIL prio_order: got tree %0d data %0d want tree %0d data %0d",
                   pop_tree, pop_data, i, want);
        end
      end
    cycle(0, 0, 0, 0, 1);
    tests_run++;
    if (pop_data !== 18'd0 || pop_tree !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL prio_empty_pop: got tree %0d data %0d want 0/0", pop_tree, pop_data);
    end
  endtask

  task automatic test_fifo_order();
    for (int k = 1; k <= 5; k++) cycle(1, 2'((k - 1) % 4), 4'd7, 18'(k), 0);
    for (int k = 1; k <= 5; k++) begin
      cycle(0, 0, 0, 0, 1);
      tests_run++;
      if (pop_data !== 18'(k) || pop_tree !== 2'((k - 1) % 4)) begin
        tests_failed++;
        $display("[TB] FAIL fifo_order: got tree %0d data %0d want tree %0d data %0d",
                 pop_tree, pop_data, (k - 1) % 4, k);
      end
    end
  endtask

  task automatic test_full_drop();
    logic [19:0] orig [$];
    logic [19:0] v;
    for (int k = 0; k < QD; k++) begin
      v = 20'($urandom);
      orig.push_back(v);
      cycle(1, v[19:18], 4'd0, v[17:0], 0);
      if (k == QD - 2) begin
        tests_run++;
        if (fifo_full !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL full_early: got %0b want 0", fifo_full);
        end
      end
    end
    tests_run++;
    if (fifo_full !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL full_set: got %0b want 1", fifo_full);
    end
    cycle(1, 2'd3, 4'd0, 18'h3ABCD, 0);
    tests_run++;
    if (fifo_full !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL full_after_drop: got %0b want 1", fifo_full);
    end
    for (int k = 0; k < QD; k++) begin
      cycle(0, 0, 0, 0, 1);
      tests_run++;
      if ({pop_tree, pop_data} !== orig[k] || pop_data !== exp_data) begin
        tests_failed++;
        $display("[TB] FAIL full_drain[%0d]: got %h want %h", k, {pop_tree, pop_data}, orig[k]);
      end
      if (k == 0) begin
        tests_run++;
        if (fifo_full !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL full_clear: got %0b want 0", fifo_full);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    cycle(1, 2'd2, 4'd2, 18'h1234, 1);
    tests_run++;
    if (pop_data !== 18'd0 || pop_tree !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL same_cycle_pop: got tree %0d data %0d want 0/0", pop_tree, pop_data);
    end
    cycle(0, 0, 0, 0, 1);
    tests_run++;
    if (pop_data !== 18'h1234 || pop_tree !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL same_cycle_next: got tree %0d data %0d want 2/%0d", pop_tree, pop_data, 18'h1234);
    end
  endtask

  task automatic test_random();
    logic [19:0] v;
    for (int n = 0; n < 600; n++) begin
      v = 20'($urandom);
      cycle(($urandom_range(0, 99) < 60), v[19:18], 4'($urandom_range(0, 3)), v[17:0],
            ($urandom_range(0, 99) < 45));
      tests_run++;
      if (pop_data !== exp_data || pop_tree !== exp_tree || fifo_full !== exp_full) begin
        tests_failed++;
        $display("[TB] FAIL random[%0d]: got tree %0d data %0d full %0b want tree %0d data %0d full %0b",
                 n, pop_tree, pop_data, fifo_full, exp_tree, exp_data, exp_full);
      end
    end
  endtask

  task automatic test_midop_reset();
    for (int k = 0; k < 3; k++) cycle(1, 2'(k), 4'(k), 18'(100 + k), 0);
    do_reset(30);
    cycle(0, 0, 0, 0, 1);
    tests_run++;
    if (pop_data !== 18'd0 || pop_tree !== 2'd0 || fifo_full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midop_reset: got tree %0d data %0d full %0b want 0/0/0",
               pop_tree, pop_data, fifo_full);
    end
  endtask

  initial begin
    test_reset();
    test_strict_priority();
    test_fifo_order();
    test_full_drop();
    test_back_to_back();
    do_reset(20);
    test_random();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
